// File: rtl/ls_mem_queue.sv
// Four-entry in-order load/store queue that issues one memory request at a time.
// A load result appears one cycle after its tag returns and is held until out_ready; in_ready drops when the queue is full.
module ls_mem_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash,
  input  logic        in_valid,
  input  logic        in_rd_mem,
  input  logic        in_wr_mem,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_size,
  input  logic [4:0]  in_dest,
  output logic        in_ready,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [1:0]  proc2mem_size,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        out_valid,
  output logic [4:0]  out_dest,
  output logic [31:0] out_value,
  input  logic        out_ready
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // A store is simply an entry that is not a load, so only rd is kept.
  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic [4:0]  dest;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  entry_t      entries [4];
  entry_t      head_e;
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  count;
  logic [3:0]  tag;
  state_t      state;
  state_t      state_next;
  logic        push;
  logic        pop;
  logic        accepted;
  logic        tag_hit;
  logic [31:0] raw;
  logic [31:0] load_value;

  assign head_e   = entries[head];
  assign in_ready = (count < 3'd4);
  assign push     = in_valid && in_ready && (in_rd_mem || in_wr_mem) && !squash;
  assign accepted = (state == S_REQ) && (mem2proc_response != 4'd0);
  assign tag_hit  = (state == S_WAIT) && (mem2proc_tag != 4'd0) && (mem2proc_tag == tag);
  assign pop      = !squash && ((accepted && !head_e.rd) || ((state == S_DONE) && out_ready));

  assign raw = 32'(mem2proc_data >> {head_e.addr[2:0], 3'b000});

  always_comb begin
    load_value = raw;
    case (head_e.size[1:0])
      2'd0:    load_value = {{24{!head_e.size[2] && raw[7]}}, raw[7:0]};
      2'd1:    load_value = {{16{!head_e.size[2] && raw[15]}}, raw[15:0]};
      default: load_value = raw;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      entries[tail] <= '{rd: in_rd_mem, addr: in_addr, data: in_data, size: in_size, dest: in_dest};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) tail <= tail + 2'd1;
      if (pop)  head <= head + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  // Clearing the tag on flush makes any late return for a squashed load unmatchable.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      tag       <= 4'd0;
      out_dest  <= 5'd0;
      out_value <= 32'd0;
    end else begin
      if (accepted && head_e.rd) tag <= mem2proc_response;
      if (tag_hit) begin
        out_dest  <= head_e.dest;
        out_value <= load_value;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) state <= S_IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (count != 3'd0) state_next = S_REQ;
      S_REQ:  if (accepted) state_next = head_e.rd ? S_WAIT : S_IDLE;
      S_WAIT: if (tag_hit) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 32'd0;
    proc2mem_data    = 64'd0;
    proc2mem_size    = 2'd0;
    out_valid        = 1'b0;
    case (state)
      S_REQ: begin
        if (!squash) proc2mem_command = head_e.rd ? BUS_LOAD : BUS_STORE;
        proc2mem_addr = head_e.addr;
        proc2mem_data = {32'd0, head_e.data} << {head_e.addr[2:0], 3'b000};
        proc2mem_size = head_e.size[1:0];
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
